// File: rtl/game_pkg.sv
// Shared types and screen-index helpers for the game screen sequencer.
package game_pkg;

    localparam int unsigned IDX_W               = 4;
    localparam int unsigned NUM_SCREENS_DEFAULT = 13;

    typedef logic [IDX_W-1:0] idx_t;

    typedef enum logic {
        IDLE,
        SHOW
    } state_t;

    // Content screens run 1..last; 0 is reserved for the black idle screen.
    function automatic idx_t idx_next(input idx_t idx, input idx_t last);
        return (idx >= last) ? idx_t'(1) : idx + idx_t'(1);
    endfunction

    function automatic idx_t idx_prev(input idx_t idx, input idx_t last);
        return (idx <= idx_t'(1)) ? last : idx - idx_t'(1);
    endfunction

endpackage

// File: rtl/game_screen_sequencer_if.sv
// User-facing switch/button inputs and screen outputs of the sequencer.
interface game_screen_sequencer_if;
    import game_pkg::*;

    logic sw;
    logic btnR;
    logic btnL;
    idx_t screen_idx;
    logic active;
    logic screen_changed;

    modport master (
        output sw, btnR, btnL,
        input  screen_idx, active, screen_changed
    );

    modport slave (
        input  sw, btnR, btnL,
        output screen_idx, active, screen_changed
    );

endinterface

// File: rtl/btn_debounce.sv
// Debounces an already-synchronized button and emits one press pulse per 0->1 level change.
module btn_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic in,
    output logic level,
    output logic press
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

    logic [CNT_W-1:0] cnt;

    // The level flips on the cycle the Nth consecutive differing sample arrives,
    // and the press pulse is registered on that same edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt   <= '0;
            level <= 1'b0;
            press <= 1'b0;
        end else begin
            press <= 1'b0;
            if (in == level) begin
                cnt <= '0;
            end else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                cnt   <= '0;
                level <= in;
                press <= in;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/game_screen_sequencer.sv
// Steps through content screens on debounced next/prev presses, with optional auto-advance.
module game_screen_sequencer
    import game_pkg::*;
#(
    parameter int unsigned NUM_SCREENS     = NUM_SCREENS_DEFAULT,
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
    parameter int unsigned AUTO_ADV_CYCLES = 0
) (
    input logic                    clk,
    input logic                    rst,
    game_screen_sequencer_if.slave bus
);

    localparam int unsigned IDLE_W = (AUTO_ADV_CYCLES > 0) ? $clog2(AUTO_ADV_CYCLES + 1) : 1;
    localparam idx_t        LAST   = idx_t'(NUM_SCREENS);

    // Bit order {sw, btnL, btnR}
    logic [2:0] sync1;
    logic [2:0] sync2;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= {bus.sw, bus.btnL, bus.btnR};
            sync2 <= sync1;
        end
    end

    logic       sw_s;
    logic       next_press;
    logic       prev_press;
    logic [1:0] levels_unused;

    assign sw_s = sync2[2];

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_next (
        .clk   (clk),
        .rst   (rst),
        .in    (sync2[0]),
        .level (levels_unused[0]),
        .press (next_press)
    );

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_prev (
        .clk   (clk),
        .rst   (rst),
        .in    (sync2[1]),
        .level (levels_unused[1]),
        .press (prev_press)
    );

    state_t            state,    state_n;
    idx_t              idx,      idx_n;
    logic              changed,  changed_n;
    logic [IDLE_W-1:0] idle_cnt, idle_cnt_n;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            idx      <= '0;
            changed  <= 1'b0;
            idle_cnt <= '0;
        end else begin
            state    <= state_n;
            idx      <= idx_n;
            changed  <= changed_n;
            idle_cnt <= idle_cnt_n;
        end
    end

    always_comb begin
        state_n    = state;
        idx_n      = idx;
        idle_cnt_n = idle_cnt;
        if (!sw_s) begin
            state_n    = IDLE;
            idx_n      = '0;
            idle_cnt_n = '0;
        end else if (state == IDLE) begin
            state_n    = SHOW;
            idx_n      = idx_t'(1);
            idle_cnt_n = '0;
        end else if (next_press || prev_press) begin
            // Simultaneous next+prev cancel out but still count as activity.
            idle_cnt_n = '0;
            if (!prev_press)
                idx_n = idx_next(idx, LAST);
            else if (!next_press)
                idx_n = idx_prev(idx, LAST);
        end else if (AUTO_ADV_CYCLES > 0) begin
            if (idle_cnt == IDLE_W'(AUTO_ADV_CYCLES - 1)) begin
                idx_n      = idx_next(idx, LAST);
                idle_cnt_n = '0;
            end else begin
                idle_cnt_n = idle_cnt + IDLE_W'(1);
            end
        end
        changed_n = (idx_n != idx);
    end

    assign bus.screen_idx     = idx;
    assign bus.active         = (state == SHOW);
    assign bus.screen_changed = changed;

endmodule

// File: tb/tb_game_screen_sequencer.sv
// Bench for game_screen_sequencer: one DUT without and one with auto-advance, shared stimulus.
module tb_game_screen_sequencer;

    localparam int NS   = 13;
    localparam int DB   = 4;
    localparam int AUTO = 10;

    logic clk;
    logic rst;
    logic sw;
    logic btn_r;
    logic btn_l;

    int total;
    int passed;

    game_screen_sequencer_if if0 ();
    game_screen_sequencer_if if1 ();

    assign if0.sw   = sw;
    assign if0.btnR = btn_r;
    assign if0.btnL = btn_l;
    assign if1.sw   = sw;
    assign if1.btnR = btn_r;
    assign if1.btnL = btn_l;

    game_screen_sequencer #(
        .NUM_SCREENS     (NS),
        .DEBOUNCE_CYCLES (DB),
        .AUTO_ADV_CYCLES (0)
    ) dut0 (
        .clk (clk),
        .rst (rst),
        .bus (if0.slave)
    );

    game_screen_sequencer #(
        .NUM_SCREENS     (NS),
        .DEBOUNCE_CYCLES (DB),
        .AUTO_ADV_CYCLES (AUTO)
    ) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (if1.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act == exp)
            passed++;
        else
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    // Reference behaviour: raw inputs seen two edges late, a button counts as
    // pressed after DB consecutive samples opposite to its settled value.
    bit raw_d1 [3];
    bit raw_d2 [3];
    int run    [3];
    bit lvl    [3];
    bit prs    [3];
    int m_idx  [2];
    bit m_show [2];
    bit m_chg  [2];
    int m_quiet[2];

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 3; i++) begin
                raw_d1[i] = 0; raw_d2[i] = 0; run[i] = 0; lvl[i] = 0; prs[i] = 0;
            end
            for (int k = 0; k < 2; k++) begin
                m_idx[k] = 0; m_show[k] = 0; m_chg[k] = 0; m_quiet[k] = 0;
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                int old;
                int auto_n;
                old    = m_idx[k];
                auto_n = (k == 1) ? AUTO : 0;
                if (!raw_d2[0]) begin
                    m_show[k] = 0; m_idx[k] = 0; m_quiet[k] = 0;
                end else if (!m_show[k]) begin
                    m_show[k] = 1; m_idx[k] = 1; m_quiet[k] = 0;
                end else if (prs[1] || prs[2]) begin
                    m_quiet[k] = 0;
                    if (prs[1] && !prs[2]) m_idx[k] = m_idx[k] % NS + 1;
                    if (prs[2] && !prs[1]) m_idx[k] = (m_idx[k] + NS - 2) % NS + 1;
                end else if (auto_n > 0) begin
                    m_quiet[k]++;
                    if (m_quiet[k] == auto_n) begin
                        m_idx[k]   = m_idx[k] % NS + 1;
                        m_quiet[k] = 0;
                    end
                end
                m_chg[k] = (m_idx[k] != old);
            end
            for (int b = 1; b < 3; b++) begin
                prs[b] = 0;
                if (raw_d2[b] == lvl[b]) begin
                    run[b] = 0;
                end else begin
                    run[b]++;
                    if (run[b] == DB) begin
                        lvl[b] = raw_d2[b];
                        prs[b] = raw_d2[b];
                        run[b] = 0;
                    end
                end
            end
            for (int i = 0; i < 3; i++) raw_d2[i] = raw_d1[i];
            raw_d1[0] = sw;
            raw_d1[1] = btn_r;
            raw_d1[2] = btn_l;
        end
    end

    always @(posedge clk) begin
        #1;
        if (!rst) begin
            check("model_idx0", int'(if0.screen_idx), m_idx[0]);
            check("model_act0", int'(if0.active), int'(m_show[0]));
            check("model_chg0", int'(if0.screen_changed), int'(m_chg[0]));
            check("model_idx1", int'(if1.screen_idx), m_idx[1]);
            check("model_act1", int'(if1.active), int'(m_show[1]));
            check("model_chg1", int'(if1.screen_changed), int'(m_chg[1]));
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic press_r();
        @(negedge clk) btn_r = 1'b1;
        tick(8);
        @(negedge clk) btn_r = 1'b0;
        tick(8);
    endtask

    task automatic press_l();
        @(negedge clk) btn_l = 1'b1;
        tick(8);
        @(negedge clk) btn_l = 1'b0;
        tick(8);
    endtask

    // Ticks until the auto-advance DUT pulses screen_changed or the budget runs out.
    task automatic wait_chg1(input int budget, output int n);
        n = 0;
        do begin
            tick(1);
            n++;
        end while (!if1.screen_changed && n < budget);
    endtask

    initial begin
        int n;
        total  = 0;
        passed = 0;
        rst    = 1'b1;
        sw     = 1'b0;
        btn_r  = 1'b0;
        btn_l  = 1'b0;

        tick(2);
        check("rst_idx0", int'(if0.screen_idx), 0);
        check("rst_act0", int'(if0.active), 0);
        check("rst_chg0", int'(if0.screen_changed), 0);
        check("rst_idx1", int'(if1.screen_idx), 0);
        @(negedge clk) rst = 1'b0;
        tick(3);
        check("idle_no_sw", int'(if0.screen_idx), 0);

        // Enable: screen 1 appears three edges after sw rises
        @(negedge clk) sw = 1'b1;
        tick(2);
        check("sw_lat_early", int'(if0.screen_idx), 0);
        tick(1);
        check("sw_lat_idx", int'(if0.screen_idx), 1);
        check("sw_lat_chg", int'(if0.screen_changed), 1);
        check("sw_lat_act", int'(if0.active), 1);
        tick(1);
        check("sw_chg_oneshot", int'(if0.screen_changed), 0);

        // Held next button: one advance, 2+4+1 edges after assertion
        @(negedge clk) btn_r = 1'b1;
        tick(6);
        check("hold_before", int'(if0.screen_idx), 1);
        tick(1);
        check("hold_adv_idx", int'(if0.screen_idx), 2);
        check("hold_adv_chg", int'(if0.screen_changed), 1);
        tick(43);
        @(negedge clk) btn_r = 1'b0;
        tick(12);
        check("hold_single", int'(if0.screen_idx), 2);

        // Three-cycle glitch is rejected
        @(negedge clk) btn_r = 1'b1;
        tick(3);
        @(negedge clk) btn_r = 1'b0;
        tick(12);
        check("glitch", int'(if0.screen_idx), 2);

        // Wrap in both directions
        repeat (12) press_r();
        check("wrap_fwd", int'(if0.screen_idx), 1);
        press_l();
        check("wrap_back", int'(if0.screen_idx), 13);
        press_r();
        check("wrap_fwd2", int'(if0.screen_idx), 1);

        // Simultaneous next+prev is a no-op
        @(negedge clk) begin btn_r = 1'b1; btn_l = 1'b1; end
        tick(8);
        @(negedge clk) begin btn_r = 1'b0; btn_l = 1'b0; end
        tick(8);
        check("both_idx", int'(if0.screen_idx), 1);

        // Auto-advance period and restart on a press
        wait_chg1(40, n);
        check("auto_seen", int'(n < 40), 1);
        wait_chg1(40, n);
        check("auto_period", n, 10);
        @(negedge clk) btn_r = 1'b1;
        wait_chg1(20, n);
        check("auto_press_at7", n, 7);
        @(negedge clk) btn_r = 1'b0;
        wait_chg1(20, n);
        check("auto_restart", n, 10);
        tick(8);
        check("auto_dut0_idx", int'(if0.screen_idx), 2);

        // sw drop at screen 6
        repeat (4) press_r();
        check("pre_drop_idx", int'(if0.screen_idx), 6);
        @(negedge clk) sw = 1'b0;
        tick(2);
        check("drop_early", int'(if0.screen_idx), 6);
        tick(1);
        check("drop_idx", int'(if0.screen_idx), 0);
        check("drop_act", int'(if0.active), 0);
        check("drop_chg", int'(if0.screen_changed), 1);
        @(negedge clk) sw = 1'b1;
        tick(3);
        check("reenable_idx", int'(if0.screen_idx), 1);

        // Reset mid-debounce with the button still held afterwards
        @(negedge clk) btn_r = 1'b1;
        tick(4);
        @(negedge clk) rst = 1'b1;
        #1;
        check("mid_rst_idx", int'(if0.screen_idx), 0);
        check("mid_rst_act", int'(if0.active), 0);
        check("mid_rst_idx1", int'(if1.screen_idx), 0);
        tick(2);
        @(negedge clk) rst = 1'b0;
        tick(3);
        check("post_rst_idx", int'(if0.screen_idx), 1);
        tick(4);
        check("post_rst_press", int'(if0.screen_idx), 2);
        check("post_rst_chg", int'(if0.screen_changed), 1);
        @(negedge clk) btn_r = 1'b0;
        tick(12);
        check("post_rst_single", int'(if0.screen_idx), 2);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/game_screen_sequencer.md
GAME_SCREEN_SEQUENCER -- requirements
Module: game_screen_sequencer

Interface
REQ-001 The module SHALL have parameter NUM_SCREENS, default 13, meaning the number of content screens, indexed 1..NUM_SCREENS.
REQ-002 The module SHALL have parameter DEBOUNCE_CYCLES, default 1_000_000, meaning the consecutive stable cycles needed to accept a button level.
REQ-003 The module SHALL have parameter AUTO_ADV_CYCLES, default 0, meaning the idle cycles before an automatic advance; 0 disables auto-advance.
REQ-004 The module SHALL have one clock and an asynchronous, active-high reset, with these ports:
- clk  in  1  single clock.
- rst  in  1  asynchronous active-high reset.
- sw  in  1  raw enable switch.
- btnR  in  1  raw "next" button.
- btnL  in  1  raw "previous" button.
- screen_idx  out  4  current screen; 0 = idle/black.
- active  out  1  high while not idle.
- screen_changed  out  1  one-cycle pulse when screen_idx changes.

Function
REQ-005 Each of sw, btnR and btnL SHALL pass through its own 2-flop synchronizer before any other use.
REQ-006 btnR and btnL SHALL each be debounced: the debounced level updates only after the synchronized input has differed from it for DEBOUNCE_CYCLES consecutive cycles; any bounce restarts the count.
REQ-007 A one-cycle registered press pulse SHALL be generated on each 0->1 edge of a debounced level; a held button produces exactly one pulse.
REQ-008 The FSM SHALL have two states, IDLE and SHOW.
REQ-009 In IDLE: screen_idx=0 and active=0.
REQ-010 IDLE->SHOW SHALL occur on the edge after synchronized sw=1, loading screen_idx=1 and pulsing screen_changed.
REQ-011 In any state, synchronized sw=0 SHALL force IDLE on the next edge with screen_idx=0; screen_changed pulses only if screen_idx was nonzero.
REQ-012 In SHOW, a next pulse SHALL set screen_idx to idx+1, wrapping from NUM_SCREENS to 1.
REQ-013 In SHOW, a prev pulse SHALL set screen_idx to idx-1, wrapping from 1 to NUM_SCREENS.
REQ-014 If next and prev pulses occur in the same cycle, screen_idx SHALL be unchanged and screen_changed SHALL stay low.
REQ-015 screen_idx SHALL update on the edge at which the press pulse is high; screen_changed SHALL be high in the same cycle that the new screen_idx is visible.
REQ-016 When AUTO_ADV_CYCLES>0, an idle counter SHALL count SHOW cycles without a press pulse; on reaching AUTO_ADV_CYCLES-1 it SHALL advance as for next and clear.
REQ-017 The idle counter SHALL clear on any press pulse (including simultaneous next+prev) and whenever in IDLE.
REQ-018 Button presses in IDLE SHALL be ignored and SHALL NOT be remembered.
REQ-019 The idle counter SHALL be clog2(AUTO_ADV_CYCLES+1) bits and the debounce counters clog2(DEBOUNCE_CYCLES+1) bits; no counter SHALL wrap.

Reset
REQ-020 While rst=1, all flops SHALL clear asynchronously: state=IDLE, screen_idx=0, active=0, screen_changed=0, all synchronizers, debounced levels and counters 0.
REQ-021 A reset asserted mid-debounce or mid-count SHALL discard partial progress; after release, a button already held SHALL produce one press pulse once debounced.

Structure
REQ-022 The state encoding (IDLE, SHOW), the 4-bit screen-index width, and the default NUM_SCREENS SHALL live in shared package game_pkg, which the screen mux also uses.
REQ-023 Debounce plus edge detect SHALL be a sub-module btn_debounce (params DEBOUNCE_CYCLES; ports clk, rst, in, level, press), instantiated twice.

Verification (DEBOUNCE_CYCLES=4, NUM_SCREENS=13 unless noted)
REQ-024 sw 0->1, no buttons -> screen_idx=1 and one screen_changed pulse 3 cycles after the sw edge; active=1.
REQ-025 btnR held 50 cycles at idx=1 -> exactly one advance to 2, occurring 2+4+1 cycles after assertion; a 3-cycle glitch causes no advance.
REQ-026 Thirteen btnR presses from idx=1 -> idx ends at 1 (wrapped 13->1); one btnL press at 1 -> idx=13.
REQ-027 btnR and btnL asserted on the same cycle -> idx unchanged, no screen_changed pulse, idle counter cleared.
REQ-028 AUTO_ADV_CYCLES=10 with no presses -> idx increments every 10 cycles; a press at cycle 7 restarts the 10-cycle count.
REQ-029 sw dropped at idx=6, or rst pulsed mid-debounce -> idx=0 and active=0; re-enabling sw restarts at idx=1.
